// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared constants and helpers for the fifo_buffer line buffer.
//   DATA_WIDTH_DEF / FIFO_SIZE_DEF / ADDR_WIDTH_DEF : default geometry
//                                                     (16-bit words, 720-entry row).
//   clog2_f : ceiling log2, used to check that ADDR_WIDTH can index FIFO_SIZE.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FIFO_SIZE_DEF  = 720;
  localparam int ADDR_WIDTH_DEF = 10;

  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr -- wrapping address pointer for one side of the FIFO.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, pointer -> 0
//   clr_n   : synchronous active-low clear, wins over inc
//   inc     : advance by one; SIZE-1 wraps to 0
//   ptr     : current pointer value
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int SIZE  = FIFO_SIZE_DEF,
  parameter int WIDTH = ADDR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_n,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(SIZE - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (!clr_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer -- single-clock line-buffer FIFO with explicit pointer control.
//   FIFO_Clk       : clock, all state changes on the rising edge
//   FIFO_Reset_n   : asynchronous active-low reset (pointers and read data -> 0,
//                    memory contents untouched)
//   FIFO_Rdptclr   : synchronous active-low read-pointer clear
//   FIFO_Wrptclr   : synchronous active-low write-pointer clear
//   FIFO_Rdinc     : advance read pointer, only while FIFO_Ren=1
//   FIFO_Wrinc     : advance write pointer, only while FIFO_Wen=1
//   FIFO_Wen       : write FIFO_Data_in at the write pointer
//   FIFO_Ren       : load FIFO_Data_out from the read pointer (1-cycle latency)
//   FIFO_Data_in   : write data
//   FIFO_Data_out  : registered read data, holds while FIFO_Ren=0
// Build option FIFO_STATUS_EN adds FIFO_Count / FIFO_Empty / FIFO_Full, an
// advisory occupancy count that does not gate reads or writes.
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_SIZE  = FIFO_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  FIFO_Clk,
  input  logic                  FIFO_Reset_n,
  input  logic                  FIFO_Rdptclr,
  input  logic                  FIFO_Wrptclr,
  input  logic                  FIFO_Rdinc,
  input  logic                  FIFO_Wrinc,
  input  logic                  FIFO_Wen,
  input  logic                  FIFO_Ren,
  input  logic [DATA_WIDTH-1:0] FIFO_Data_in,
`ifdef FIFO_STATUS_EN
  output logic [ADDR_WIDTH:0]   FIFO_Count,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full,
`endif
  output logic [DATA_WIDTH-1:0] FIFO_Data_out
);

  if (ADDR_WIDTH < clog2_f(FIFO_SIZE)) begin : g_bad_addr_width
    $error("fifo_buffer: ADDR_WIDTH too small for FIFO_SIZE");
  end

  logic [ADDR_WIDTH-1:0] wrptr;
  logic [ADDR_WIDTH-1:0] rdptr;
  logic                  wr_adv;
  logic                  rd_adv;
  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [DATA_WIDTH-1:0] rd_data_p1;

  // Increments are only honoured alongside their access enable.
  assign wr_adv = FIFO_Wen & FIFO_Wrinc;
  assign rd_adv = FIFO_Ren & FIFO_Rdinc;

  fifo_ptr #(.SIZE(FIFO_SIZE), .WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk     (FIFO_Clk),
    .reset_n (FIFO_Reset_n),
    .clr_n   (FIFO_Wrptclr),
    .inc     (wr_adv),
    .ptr     (wrptr)
  );

  fifo_ptr #(.SIZE(FIFO_SIZE), .WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk     (FIFO_Clk),
    .reset_n (FIFO_Reset_n),
    .clr_n   (FIFO_Rdptclr),
    .inc     (rd_adv),
    .ptr     (rdptr)
  );

  // Memory has no reset so it maps onto simple dual-port block RAM.
  always_ff @(posedge FIFO_Clk) begin
    if (FIFO_Wen) mem[wrptr] <= FIFO_Data_in;
  end

  // ---- stage p1: registered read; same-address access returns old data ----
  always_ff @(posedge FIFO_Clk or negedge FIFO_Reset_n) begin
    if (!FIFO_Reset_n) begin
      rd_data_p1 <= '0;
    end else if (FIFO_Ren) begin
      rd_data_p1 <= mem[rdptr];
    end
  end

  assign FIFO_Data_out = rd_data_p1;

`ifdef FIFO_STATUS_EN
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_SIZE);

  logic [CNT_W-1:0] count_p1;

  // Either pointer clear invalidates the occupancy, so restart from empty.
  always_ff @(posedge FIFO_Clk or negedge FIFO_Reset_n) begin
    if (!FIFO_Reset_n) begin
      count_p1 <= '0;
    end else if (!FIFO_Wrptclr || !FIFO_Rdptclr) begin
      count_p1 <= '0;
    end else if (wr_adv && !rd_adv) begin
      if (count_p1 != CNT_MAX) count_p1 <= count_p1 + CNT_W'(1);
    end else if (rd_adv && !wr_adv) begin
      if (count_p1 != '0) count_p1 <= count_p1 - CNT_W'(1);
    end
  end

  assign FIFO_Count = count_p1;
  assign FIFO_Empty = (count_p1 == '0);
  assign FIFO_Full  = (count_p1 == CNT_MAX);
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer -- self-checking bench for fifo_buffer against a queue/array
// reference model. Define FIFO_STATUS_EN to also check the status outputs.
module tb_fifo_buffer;

  localparam int DW = 16;
  localparam int SZ = 720;
  localparam int AW = 10;

  logic          tb_clk = 1'b0;
  logic          rst_n;
  logic          rdptclr_n;
  logic          wrptclr_n;
  logic          rdinc;
  logic          wrinc;
  logic          wen;
  logic          ren;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
`ifdef FIFO_STATUS_EN
  logic [AW:0]   cnt;
  logic          empty;
  logic          full;
`endif

  always #5 tb_clk = ~tb_clk;

  fifo_buffer #(.DATA_WIDTH(DW), .FIFO_SIZE(SZ), .ADDR_WIDTH(AW)) dut (
    .FIFO_Clk      (tb_clk),
    .FIFO_Reset_n  (rst_n),
    .FIFO_Rdptclr  (rdptclr_n),
    .FIFO_Wrptclr  (wrptclr_n),
    .FIFO_Rdinc    (rdinc),
    .FIFO_Wrinc    (wrinc),
    .FIFO_Wen      (wen),
    .FIFO_Ren      (ren),
    .FIFO_Data_in  (din),
`ifdef FIFO_STATUS_EN
    .FIFO_Count    (cnt),
    .FIFO_Empty    (empty),
    .FIFO_Full     (full),
`endif
    .FIFO_Data_out (dout)
  );

  // Reference model state
  logic [DW-1:0] m_mem [SZ];
  int            m_wr;
  int            m_rd;
  int            m_cnt;
  logic [DW-1:0] m_out;

  int n_cmp = 0;
  int n_err = 0;

  // Drive one cycle's inputs, let the edge happen, advance the model, then
  // return 1 time unit after the edge so callers sample away from it.
  task automatic step(input logic i_wen, input logic i_wrinc, input logic [DW-1:0] i_din,
                      input logic i_ren, input logic i_rdinc,
                      input logic i_wclr_n, input logic i_rclr_n);
    bit wa, ra;
    wen = i_wen; wrinc = i_wrinc; din = i_din;
    ren = i_ren; rdinc = i_rdinc;
    wrptclr_n = i_wclr_n; rdptclr_n = i_rclr_n;
    @(posedge tb_clk);
    if (i_ren) m_out = m_mem[m_rd];
    if (i_wen) m_mem[m_wr] = i_din;
    wa = i_wen && i_wrinc;
    ra = i_ren && i_rdinc;
    if (!i_wclr_n) m_wr = 0; else if (wa) m_wr = (m_wr + 1) % SZ;
    if (!i_rclr_n) m_rd = 0; else if (ra) m_rd = (m_rd + 1) % SZ;
    if (!i_wclr_n || !i_rclr_n) m_cnt = 0;
    else if (wa && !ra) m_cnt = (m_cnt >= SZ) ? SZ : m_cnt + 1;
    else if (ra && !wa) m_cnt = (m_cnt <= 0) ? 0 : m_cnt - 1;
    #1;
  endtask

  task automatic test_reset();
    wen = 0; wrinc = 0; ren = 0; rdinc = 0; din = '0;
    wrptclr_n = 1; rdptclr_n = 1; rst_n = 0;
    repeat (2) @(posedge tb_clk);
    #1;
    n_cmp++;
    if (dout !== '0) begin n_err++; $display("FAIL reset_dout got=%h exp=0000", dout); end
`ifdef FIFO_STATUS_EN
    n_cmp++;
    if (cnt !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL reset_status got cnt=%0d e=%b f=%b exp cnt=0 e=1 f=0", cnt, empty, full);
    end
`endif
    rst_n = 1;
    m_wr = 0; m_rd = 0; m_cnt = 0; m_out = '0;
    step(0, 0, '0, 0, 0, 1, 1);
    n_cmp++;
    if (dout !== '0) begin n_err++; $display("FAIL reset_idle got=%h exp=0000", dout); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 9; i++) step(1, 1, DW'(i + 1), 0, 0, 1, 1);
    repeat (2) step(0, 0, '0, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, '0, 1, 1, 1, 1);
      n_cmp++;
      if (dout !== DW'(i + 1)) begin
        n_err++; $display("FAIL burst[%0d] got=%h exp=%h", i, dout, DW'(i + 1));
      end
    end
  endtask

  task automatic test_enables();
    // Ren=0 holds the output while unrelated writes are attempted with Wen=0
    for (int i = 0; i < 3; i++) begin
      step(0, 1, DW'($urandom), 0, 0, 1, 1);
      n_cmp++;
      if (dout !== 16'd9) begin n_err++; $display("FAIL hold[%0d] got=%h exp=0009", i, dout); end
    end
    // Non-advancing writes rewrite one location
    step(1, 0, 16'd7, 0, 0, 1, 1);
    step(1, 0, 16'd8, 0, 0, 1, 1);
    // Rdinc without Ren must not move the read pointer
    step(0, 0, '0, 0, 1, 1, 1);
    step(0, 0, '0, 0, 1, 1, 1);
    step(0, 0, '0, 1, 0, 1, 1);
    n_cmp++;
    if (dout !== 16'd8) begin n_err++; $display("FAIL rewrite got=%h exp=0008", dout); end
    // Same location again proves the write pointer stayed put
    step(1, 1, 16'h0055, 0, 0, 1, 1);
    step(0, 0, '0, 1, 1, 1, 1);
    n_cmp++;
    if (dout !== 16'h0055) begin n_err++; $display("FAIL wrptr_hold got=%h exp=0055", dout); end
    // Wrinc without Wen must not move the write pointer
    step(0, 1, '0, 0, 0, 1, 1);
    step(0, 1, '0, 0, 0, 1, 1);
    step(1, 1, 16'h0066, 0, 0, 1, 1);
    step(0, 0, '0, 1, 1, 1, 1);
    n_cmp++;
    if (dout !== 16'h0066) begin n_err++; $display("FAIL wrinc_gated got=%h exp=0066", dout); end
  endtask

  task automatic test_ptr_clear();
    step(1, 1, 16'h0077, 0, 0, 1, 1);
    // Clear with read+inc: this edge reads the pre-clear location
    step(0, 0, '0, 1, 1, 1, 0);
    n_cmp++;
    if (dout !== 16'h0077) begin n_err++; $display("FAIL rdclr_preread got=%h exp=0077", dout); end
    step(0, 0, '0, 1, 1, 1, 1);
    n_cmp++;
    if (dout !== 16'd1) begin n_err++; $display("FAIL rdclr_restart got=%h exp=0001", dout); end
    // Write during clear lands at the pre-clear address, then next write at 0
    step(1, 1, 16'h4321, 0, 0, 0, 1);
    step(1, 1, 16'hABCD, 0, 0, 1, 1);
    step(0, 0, '0, 0, 0, 1, 0);
    step(0, 0, '0, 1, 1, 1, 1);
    n_cmp++;
    if (dout !== 16'hABCD) begin n_err++; $display("FAIL wrclr_mem0 got=%h exp=abcd", dout); end
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, '0, 1, 1, 1, 1);
      n_cmp++;
      if (dout !== m_out) begin n_err++; $display("FAIL clr_scan[%0d] got=%h exp=%h", i, dout, m_out); end
    end
    n_cmp++;
    if (dout !== 16'h4321) begin n_err++; $display("FAIL wrclr_preaddr got=%h exp=4321", dout); end
  endtask

  task automatic test_same_addr();
    step(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, DW'($urandom), 0, 0, 1, 1);
    step(1, 0, 16'h0011, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 1, 1, 1, 1);
      n_cmp++;
      if (dout !== m_out) begin n_err++; $display("FAIL same_pre[%0d] got=%h exp=%h", i, dout, m_out); end
    end
    step(1, 0, 16'h0022, 1, 0, 1, 1);
    n_cmp++;
    if (dout !== 16'h0011) begin n_err++; $display("FAIL same_addr_old got=%h exp=0011", dout); end
    step(0, 0, '0, 1, 0, 1, 1);
    n_cmp++;
    if (dout !== 16'h0022) begin n_err++; $display("FAIL same_addr_new got=%h exp=0022", dout); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp;
    step(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < SZ; i++) step(1, 1, DW'(i), 0, 0, 1, 1);
`ifdef FIFO_STATUS_EN
    n_cmp++;
    if (cnt !== 11'd720 || full !== 1'b1 || empty !== 1'b0) begin
      n_err++; $display("FAIL full got cnt=%0d f=%b e=%b exp cnt=720 f=1 e=0", cnt, full, empty);
    end
`endif
    for (int i = 0; i < 5; i++) step(1, 1, DW'(1000 + i), 0, 0, 1, 1);
`ifdef FIFO_STATUS_EN
    n_cmp++;
    if (cnt !== 11'd720 || full !== 1'b1) begin
      n_err++; $display("FAIL full_sat got cnt=%0d f=%b exp cnt=720 f=1", cnt, full);
    end
`endif
    for (int i = 0; i < SZ + 5; i++) begin
      step(0, 0, '0, 1, 1, 1, 1);
      if (i < 5) exp = DW'(1000 + i);
      else if (i < SZ) exp = DW'(i);
      else exp = DW'(1000 + i - SZ);
      n_cmp++;
      if (dout !== exp) begin n_err++; $display("FAIL wrap[%0d] got=%h exp=%h", i, dout, exp); end
`ifdef FIFO_STATUS_EN
      if (i == SZ - 1) begin
        n_cmp++;
        if (cnt !== '0 || empty !== 1'b1) begin
          n_err++; $display("FAIL drained got cnt=%0d e=%b exp cnt=0 e=1", cnt, empty);
        end
      end
`endif
    end
`ifdef FIFO_STATUS_EN
    n_cmp++;
    if (cnt !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL empty_sat got cnt=%0d e=%b f=%b exp cnt=0 e=1 f=0", cnt, empty, full);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 31) != 0), ($urandom_range(0, 31) != 0));
      n_cmp++;
      if (dout !== m_out) begin n_err++; $display("FAIL rand[%0d] got=%h exp=%h", i, dout, m_out); end
`ifdef FIFO_STATUS_EN
      n_cmp++;
      if (cnt !== (AW + 1)'(m_cnt) || empty !== (m_cnt == 0) || full !== (m_cnt == SZ)) begin
        n_err++;
        $display("FAIL rand_status[%0d] got cnt=%0d e=%b f=%b exp cnt=%0d", i, cnt, empty, full, m_cnt);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 16'h1357, 1, 1, 1, 1);
    wen = 1; wrinc = 1; ren = 1; rdinc = 1; din = 16'h2468;
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (dout !== '0) begin n_err++; $display("FAIL async_reset got=%h exp=0000", dout); end
`ifdef FIFO_STATUS_EN
    n_cmp++;
    if (cnt !== '0 || empty !== 1'b1) begin
      n_err++; $display("FAIL async_reset_cnt got cnt=%0d e=%b exp cnt=0 e=1", cnt, empty);
    end
`endif
    wen = 0; wrinc = 0; ren = 0; rdinc = 0;
    @(posedge tb_clk);
    #1 rst_n = 1;
    m_wr = 0; m_rd = 0; m_cnt = 0; m_out = '0;
    step(0, 0, '0, 1, 0, 1, 1);
    n_cmp++;
    if (dout !== m_out) begin n_err++; $display("FAIL post_reset_read got=%h exp=%h", dout, m_out); end
    step(1, 1, 16'hBEEF, 0, 0, 1, 1);
    step(0, 0, '0, 1, 0, 1, 1);
    n_cmp++;
    if (dout !== 16'hBEEF) begin n_err++; $display("FAIL post_reset_wrptr got=%h exp=beef", dout); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_enables();
    test_ptr_clear();
    test_same_addr();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
